// File: rtl/fitness_pkg.sv
// Shared types for the full-adder fitness scorer: test-vector layout, FSM states, fitness width.
package fitness_pkg;

  typedef struct packed {
    logic a;
    logic b;
    logic ci;
    logic sum_exp;
    logic co_exp;
  } test_vec_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  // Two scored outputs per vector, so the count spans 0..2*test_count inclusive.
  function automatic int fit_w(input int test_count);
    return $clog2(2 * test_count + 1);
  endfunction

endpackage

// File: rtl/fitness_vec_mem.sv
// Test-vector store: one synchronous write port, one combinational read port, contents never reset.
module fitness_vec_mem
  import fitness_pkg::*;
#(
  parameter int TEST_COUNT = 8,
  localparam int AW = $clog2(TEST_COUNT),
  localparam int VW = $bits(test_vec_t)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [VW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [VW-1:0] rdata
);

  logic [VW-1:0] mem [TEST_COUNT];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fitness_scorer.sv
// Drives stored vectors into a candidate full adder and counts matching outputs; a pass takes
// TEST_COUNT*(2+SETTLE_CYCLES)+1 cycles to the done pulse. Define FITNESS_SCORER_FAIL_MASK_EN for fail_mask.
module fitness_scorer
  import fitness_pkg::*;
#(
  parameter int TEST_COUNT    = 8,
  parameter int SETTLE_CYCLES = 1,
  localparam int AW = $clog2(TEST_COUNT),
  localparam int FW = fit_w(TEST_COUNT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          vec_we,
  input  logic [AW-1:0] vec_addr,
  input  logic [4:0]    vec_wdata,
  output logic          dut_a,
  output logic          dut_b,
  output logic          dut_ci,
  input  logic          dut_sum,
  input  logic          dut_co,
  output logic          busy,
  output logic          done,
  output logic [FW-1:0] fitness
`ifdef FITNESS_SCORER_FAIL_MASK_EN
  ,
  output logic [TEST_COUNT-1:0] fail_mask
`endif
);

  state_t        state;
  logic [AW-1:0] idx;
  logic [3:0]    settle_cnt;
  logic [4:0]    rd_word;
  test_vec_t     cur_vec;
  logic          mem_we;
  logic          sum_ok;
  logic          co_ok;
  logic [1:0]    score;

  // Writes are only honoured while idle so a running pass sees a stable vector set.
  assign mem_we = vec_we && (state == ST_IDLE);

  fitness_vec_mem #(
    .TEST_COUNT(TEST_COUNT)
  ) u_vec_mem (
    .clk  (clk),
    .we   (mem_we),
    .waddr(vec_addr),
    .wdata(vec_wdata),
    .raddr(idx),
    .rdata(rd_word)
  );

  assign cur_vec = rd_word;

  // An unknown candidate output fails the equality test and so scores as a mismatch.
  always_comb begin
    sum_ok = 1'b0;
    co_ok  = 1'b0;
    if (dut_sum == cur_vec.sum_exp) sum_ok = 1'b1;
    if (dut_co == cur_vec.co_exp) co_ok = 1'b1;
    score = {1'b0, sum_ok} + {1'b0, co_ok};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fitness    <= '0;
      dut_a      <= 1'b0;
      dut_b      <= 1'b0;
      dut_ci     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            fitness <= '0;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          dut_a      <= cur_vec.a;
          dut_b      <= cur_vec.b;
          dut_ci     <= cur_vec.ci;
          settle_cnt <= 4'(SETTLE_CYCLES);
          state      <= (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;
        end
        ST_SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          fitness <= fitness + FW'(score);
          if (idx == AW'(TEST_COUNT - 1)) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + AW'(1);
            state <= ST_APPLY;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef FITNESS_SCORER_FAIL_MASK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_mask <= '0;
    end else if (state == ST_IDLE && start) begin
      fail_mask <= '0;
    end else if (state == ST_SAMPLE && score != 2'd2) begin
      fail_mask[idx] <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fitness_scorer.sv
// Randomized scoreboard bench for fitness_scorer with a truth-level adder/candidate reference model.
module tb_fitness_scorer;

  localparam int TC = 8;
  localparam int SC = 1;

  typedef struct {
    int            fit;
    int            lat;
    logic [TC-1:0] mask;
    int            t0;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       vec_we;
  logic [2:0] vec_addr;
  logic [4:0] vec_wdata;

  int         mode;
  logic [7:0] tt_sum;
  logic [7:0] tt_co;

  logic       m_a, m_b, m_ci, m_sum, m_co, m_busy, m_done;
  logic [4:0] m_fit;
  logic       s0_a, s0_b, s0_ci, s0_sum, s0_co, s0_busy, s0_done;
  logic [4:0] s0_fit;
  logic       s3_a, s3_b, s3_ci, s3_sum, s3_co, s3_busy, s3_done;
  logic [4:0] s3_fit;
`ifdef FITNESS_SCORER_FAIL_MASK_EN
  logic [TC-1:0] m_mask, s0_mask, s3_mask;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [4:0] mem_m [TC];
  exp_t       exp_q [$];
  exp_t       mon_e;
  logic       prev_done = 1'b0;
  int         last_fit;
  int         last_t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Candidate behaviours: 0 ideal adder, 1 parity with carry stuck low, 2 all zero, 3 random truth table.
  function automatic logic [1:0] cand(input int md, input logic [7:0] ts, input logic [7:0] tcy,
                                      input logic a, input logic b, input logic ci);
    int         s;
    logic [2:0] k;
    s = int'(a) + int'(b) + int'(ci);
    k = {a, b, ci};
    case (md)
      0:       cand = {(s % 2) == 1, s >= 2};
      1:       cand = {(s % 2) == 1, 1'b0};
      2:       cand = 2'b00;
      default: cand = {ts[k], tcy[k]};
    endcase
  endfunction

  function automatic exp_t model(input int md);
    exp_t       e;
    logic [4:0] w;
    logic [1:0] r;
    int         m;
    e.fit  = 0;
    e.mask = '0;
    e.lat  = TC * (2 + SC) + 1;
    e.t0   = 0;
    for (int i = 0; i < TC; i++) begin
      w = mem_m[i];
      r = cand(md, tt_sum, tt_co, w[4], w[3], w[2]);
      m = int'(r[1] == w[1]) + int'(r[0] == w[0]);
      e.fit += m;
      if (m != 2) e.mask[i] = 1'b1;
    end
    return e;
  endfunction

  logic [1:0] m_c, s0_c, s3_c;
  assign m_c  = cand(mode, tt_sum, tt_co, m_a, m_b, m_ci);
  assign s0_c = cand(mode, tt_sum, tt_co, s0_a, s0_b, s0_ci);
  assign s3_c = cand(mode, tt_sum, tt_co, s3_a, s3_b, s3_ci);
  assign m_sum  = m_c[1];
  assign m_co   = m_c[0];
  assign s0_sum = s0_c[1];
  assign s0_co  = s0_c[0];
  assign s3_sum = s3_c[1];
  assign s3_co  = s3_c[0];

  fitness_scorer #(.TEST_COUNT(TC), .SETTLE_CYCLES(SC)) u_dut (
    .clk(clk), .rst(rst), .start(start), .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
    .dut_a(m_a), .dut_b(m_b), .dut_ci(m_ci), .dut_sum(m_sum), .dut_co(m_co),
    .busy(m_busy), .done(m_done), .fitness(m_fit)
`ifdef FITNESS_SCORER_FAIL_MASK_EN
    , .fail_mask(m_mask)
`endif
  );

  fitness_scorer #(.TEST_COUNT(TC), .SETTLE_CYCLES(0)) u_s0 (
    .clk(clk), .rst(rst), .start(start), .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
    .dut_a(s0_a), .dut_b(s0_b), .dut_ci(s0_ci), .dut_sum(s0_sum), .dut_co(s0_co),
    .busy(s0_busy), .done(s0_done), .fitness(s0_fit)
`ifdef FITNESS_SCORER_FAIL_MASK_EN
    , .fail_mask(s0_mask)
`endif
  );

  fitness_scorer #(.TEST_COUNT(TC), .SETTLE_CYCLES(3)) u_s3 (
    .clk(clk), .rst(rst), .start(start), .vec_we(vec_we), .vec_addr(vec_addr), .vec_wdata(vec_wdata),
    .dut_a(s3_a), .dut_b(s3_b), .dut_ci(s3_ci), .dut_sum(s3_sum), .dut_co(s3_co),
    .busy(s3_busy), .done(s3_done), .fitness(s3_fit)
`ifdef FITNESS_SCORER_FAIL_MASK_EN
    , .fail_mask(s3_mask)
`endif
  );

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every done pulse from the main instance retires one scoreboard entry.
  always @(negedge clk) begin
    if (prev_done) check("done_one_cycle", int'(m_done), 0);
    prev_done = m_done;
    if (rst && m_done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check("fitness", int'(m_fit), mon_e.fit);
        check("latency", cyc - mon_e.t0, mon_e.lat);
        check("busy_at_done", int'(m_busy), 0);
`ifdef FITNESS_SCORER_FAIL_MASK_EN
        check("fail_mask", int'(m_mask), int'(mon_e.mask));
`endif
      end
    end
  end

  task automatic write_vec(input int addr, input logic [4:0] data);
    @(negedge clk);
    vec_we    = 1'b1;
    vec_addr  = 3'(addr);
    vec_wdata = data;
    mem_m[addr] = data;
    @(negedge clk);
    vec_we = 1'b0;
  endtask

  task automatic load_truth();
    int         s;
    logic [2:0] k;
    for (int i = 0; i < TC; i++) begin
      k = 3'(i);
      s = int'(k[2]) + int'(k[1]) + int'(k[0]);
      write_vec(i, {k, (s % 2) == 1, s >= 2});
    end
  endtask

  task automatic start_pass(input int md, input bit do_write);
    exp_t       e;
    int         a;
    logic [4:0] d;
    @(negedge clk);
    mode   = md;
    tt_sum = 8'($urandom);
    tt_co  = 8'($urandom);
    start  = 1'b1;
    if (do_write) begin
      a = $urandom_range(0, TC - 1);
      d = 5'($urandom);
      vec_we    = 1'b1;
      vec_addr  = 3'(a);
      vec_wdata = d;
      mem_m[a]  = d;
    end
    e = model(md);
    @(negedge clk);
    start  = 1'b0;
    vec_we = 1'b0;
    e.t0    = cyc;
    last_t0 = cyc;
    last_fit = e.fit;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      check("pass_timeout", exp_q.size(), 0);
      exp_q.delete();
    end else begin
      repeat (3) @(negedge clk);
      check("fitness_hold", int'(m_fit), last_fit);
    end
  endtask

  initial begin
    int t_s0, t_s3;
    rst = 1'b0; start = 1'b0; vec_we = 1'b0; vec_addr = '0; vec_wdata = '0;
    mode = 0; tt_sum = '0; tt_co = '0;
    for (int i = 0; i < TC; i++) mem_m[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(m_busy), 0);
    check("rst_done", int'(m_done), 0);
    check("rst_fitness", int'(m_fit), 0);
    check("rst_dut_a", int'(m_a), 0);
    check("rst_dut_b", int'(m_b), 0);
    check("rst_dut_ci", int'(m_ci), 0);
`ifdef FITNESS_SCORER_FAIL_MASK_EN
    check("rst_fail_mask", int'(m_mask), 0);
`endif
    rst = 1'b1;

    load_truth();
    start_pass(0, 1'b0); wait_drain();
    start_pass(1, 1'b0); wait_drain();
    start_pass(2, 1'b0); wait_drain();
    start_pass(0, 1'b0); wait_drain();

    // Reset ten cycles into a pass: abandoned, no done, memory kept.
    start_pass(0, 1'b0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", int'(m_busy), 0);
    check("midrst_fitness", int'(m_fit), 0);
    check("midrst_done", int'(m_done), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    start_pass(0, 1'b0); wait_drain();

    // Start and write while busy must be dropped; word 0 is probed by the all-zero candidate.
    start_pass(0, 1'b0);
    repeat (8) @(negedge clk);
    start = 1'b1; vec_we = 1'b1; vec_addr = 3'd0; vec_wdata = 5'b11111;
    @(negedge clk);
    start = 1'b0; vec_we = 1'b0;
    wait_drain();
    start_pass(2, 1'b0); wait_drain();

    start_pass(0, 1'b1); wait_drain();

    for (int p = 0; p < 15; p++) begin
      for (int i = 0; i < TC; i++) if ($urandom_range(0, 1) == 1) write_vec(i, 5'($urandom));
      start_pass($urandom_range(0, 3), $urandom_range(0, 1) == 1);
      wait_drain();
    end

    // Settle-length variants, all instances idle with the truth table loaded.
    repeat (60) @(negedge clk);
    load_truth();
    start_pass(0, 1'b0);
    t_s0 = -1;
    t_s3 = -1;
    for (int k = 0; k < 100 && (t_s0 < 0 || t_s3 < 0); k++) begin
      @(negedge clk);
      if (s0_done && t_s0 < 0) t_s0 = cyc - last_t0;
      if (s3_done && t_s3 < 0) t_s3 = cyc - last_t0;
    end
    check("s0_latency", t_s0, TC * 2 + 1);
    check("s3_latency", t_s3, TC * 5 + 1);
    check("s0_fitness", int'(s0_fit), 2 * TC);
    check("s3_fitness", int'(s3_fit), 2 * TC);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/fitness_scorer.md
FITNESS_SCORER -- requirements
Module: fitness_scorer

Interface
REQ-001 SHALL have parameter TEST_COUNT, default 8: number of test vectors per evaluation (2..256).
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1: wait cycles between applying a vector and sampling the candidate (0..15).
REQ-003 SHALL have port clk  input  1: single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1: request one evaluation pass; sampled in IDLE only.
REQ-006 SHALL have port vec_we  input  1: vector memory write enable.
REQ-007 SHALL have port vec_addr  input  clog2(TEST_COUNT): vector memory write address.
REQ-008 SHALL have port vec_wdata  input  5: packed vector {a, b, ci, sum_exp, co_exp}, MSB first.
REQ-009 SHALL have ports dut_a, dut_b, dut_ci  output  1 each: registered stimulus to the candidate full adder.
REQ-010 SHALL have ports dut_sum, dut_co  input  1 each: candidate outputs.
REQ-011 SHALL have port busy  output  1: high from accepted start until DONE state exits.
REQ-012 SHALL have port done  output  1: single-cycle pulse at end of pass.
REQ-013 SHALL have port fitness  output  clog2(2*TEST_COUNT+1): matched-output count of last pass.

Function
REQ-014 SHALL implement FSM IDLE -> APPLY -> SETTLE -> SAMPLE -> (APPLY | DONE) -> IDLE.
REQ-015 IDLE: start=1 SHALL clear fitness and vector index to 0 and go to APPLY; start=0 stays IDLE.
REQ-016 APPLY: SHALL register a/b/ci of vector[index] onto dut_a/dut_b/dut_ci, load settle counter, go to SETTLE (skip directly to SAMPLE when SETTLE_CYCLES=0).
REQ-017 SETTLE: SHALL hold stimulus for exactly SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-018 SAMPLE: SHALL add (dut_sum==sum_exp) + (dut_co==co_exp), i.e. 0, 1 or 2, to fitness.
REQ-019 SAMPLE: index==TEST_COUNT-1 SHALL go to DONE; otherwise index increments and goes to APPLY.
REQ-020 DONE: SHALL assert done for exactly one cycle and return to IDLE; fitness holds until next accepted start.
REQ-021 Pass length SHALL be TEST_COUNT*(2+SETTLE_CYCLES)+1 cycles from start-accept edge to done pulse (defaults: 25).
REQ-022 fitness SHALL never wrap; maximum 2*TEST_COUNT.
REQ-023 start while busy SHALL be ignored, with no queued request.
REQ-024 vec_we while busy SHALL be ignored; vec_we in IDLE SHALL write on that edge, and a same-cycle start SHALL see the new data.
REQ-025 X on dut_sum/dut_co SHALL count as mismatch.

Reset
REQ-026 rst low SHALL immediately force IDLE; busy, done, fitness, dut_a/b/ci, index and settle counter to 0.
REQ-027 Reset mid-pass SHALL abandon the pass with no done pulse; vector memory contents are not reset and SHALL be retained.

Configuration
REQ-028 Macro FITNESS_SCORER_FAIL_MASK_EN defined SHALL add output fail_mask [TEST_COUNT-1:0]: bit i set when vector i had any mismatch, cleared on start-accept and reset, valid from done.
REQ-029 Macro FITNESS_SCORER_FAIL_MASK_EN undefined SHALL omit the fail_mask port and its logic; all other behaviour SHALL be identical.

Structure
REQ-030 Package fitness_pkg SHALL hold the packed test-vector struct typedef (a, b, ci, sum_exp, co_exp), the FSM state enum and the fitness width function.
REQ-031 Vector storage SHALL be sub-module fitness_vec_mem (one write port, one combinational read port, TEST_COUNT x 5 bits).

Verification
REQ-032 Load the 8 full-adder truth-table vectors, candidate = ideal adder, start -> done at cycle 25, fitness=16.
REQ-033 Same vectors, candidate sum=a^b^ci, co=0 -> fitness=12; with FITNESS_SCORER_FAIL_MASK_EN, fail_mask=8'b1110_1000 (vectors 3,5,6,7 fail).
REQ-034 Candidate sum=0, co=0 -> fitness=8; a second start with the ideal adder -> fitness=16, with no carry-over.
REQ-035 Assert rst low at cycle 10 of a pass -> busy=0, fitness=0, no done pulse; then start -> normal pass, fitness=16.
REQ-036 Pulse start and vec_we (addr 0, data 5'b11111) mid-pass -> pass unaffected, fitness=16, memory word 0 unchanged.
REQ-037 SETTLE_CYCLES=0 and =3 -> done at cycles 17 and 41 respectively, fitness=16.
